// File: rtl/rs_frame_sched.sv
// rs_frame_sched: frame scheduler for an RS(N,K) encoder/decoder pair.
// After reset it counts out decoder initialisation, then on start runs one
// codeword: message-ROM address and encoder enables, decoder enable one
// cycle behind, decoder output position tracking, frame end or timeout.
// Optional feature macro: ERR_COUNT_EN (per-frame nonzero dec_error count).
// Ports:
//   clk          in   rising-edge clock
//   clr          in   asynchronous reset, active-high
//   start        in   frame request pulse, honoured only while ready
//   dec_valid    in   decoder output-valid strobe
//   dec_error    in   [7:0] decoded error symbol (ERR_COUNT_EN only)
//   ready        out  idle, init complete, no frame in flight
//   busy         out  frame in flight (encode or wait-for-decoder)
//   enc_ena      out  encoder clock enable
//   data_present out  encoder input-latch enable (message symbols)
//   address      out  [7:0] message ROM address / encoder symbol index
//   dec_ena      out  decoder clock enable
//   position     out  [7:0] index of current decoder output symbol
//   done         out  one-cycle frame-end pulse
//   timeout      out  sticky: last frame ended by timeout
//   err_cnt      out  [7:0] nonzero dec_error count of the current frame
module rs_frame_sched #(
    parameter int N         = 255,
    parameter int K         = 239,
    parameter int INIT_WAIT = 256,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       dec_valid,
    input  logic [7:0] dec_error,
    output logic       ready,
    output logic       busy,
    output logic       enc_ena,
    output logic       data_present,
    output logic [7:0] address,
    output logic       dec_ena,
    output logic [7:0] position,
    output logic       done,
    output logic       timeout,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_ENC  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam int IW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_WAIT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    LAST_SYM  = 8'(N - 1);
    localparam logic [7:0]    MSG_LEN   = 8'(K);

    state_t        state_q, state_d;
    logic [IW-1:0] init_q, init_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    pos_q, pos_d;
    logic          dec_ena_q, dec_ena_d;
    logic          done_q, done_d;
    logic          to_q, to_d;
    logic          end_q, end_d;
    logic          start_ok;
    logic          end_now;

    // ready drops for the done cycle so a start there is not taken
    assign ready        = (state_q == S_IDLE) && !done_q;
    assign busy         = (state_q == S_ENC) || (state_q == S_WAIT);
    assign enc_ena      = (state_q == S_ENC);
    assign data_present = enc_ena && (addr_q < MSG_LEN);
    assign address      = addr_q;
    assign dec_ena      = dec_ena_q;
    assign position     = pos_q;
    assign done         = done_q;
    assign timeout      = to_q;

    assign start_ok = ready && start;
    assign end_now  = dec_valid && (pos_q == LAST_SYM);

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        tcnt_d    = tcnt_q;
        addr_d    = addr_q;
        pos_d     = pos_q;
        dec_ena_d = enc_ena;
        done_d    = 1'b0;
        to_d      = to_q;
        end_d     = end_q;

        if (state_q != S_INIT) begin
            pos_d = dec_valid ? pos_q + 8'd1 : 8'd0;
        end

        unique case (state_q)
            S_INIT: begin
                if (init_q == INIT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_ENC;
                    addr_d  = 8'd0;
                    to_d    = 1'b0;
                    end_d   = 1'b0;
                end
            end
            S_ENC: begin
                if (addr_q == LAST_SYM) begin
                    addr_d = 8'd0;
                    // an end seen while encoding finishes the frame here
                    if (end_q || end_now) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        tcnt_d  = '0;
                    end
                end else begin
                    addr_d = addr_q + 8'd1;
                    if (end_now) begin
                        end_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (end_now) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (tcnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    tcnt_d = dec_valid ? '0 : tcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_INIT;
            init_q    <= '0;
            tcnt_q    <= '0;
            addr_q    <= 8'd0;
            pos_q     <= 8'd0;
            dec_ena_q <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            tcnt_q    <= tcnt_d;
            addr_q    <= addr_d;
            pos_q     <= pos_d;
            dec_ena_q <= dec_ena_d;
            done_q    <= done_d;
            to_q      <= to_d;
            end_q     <= end_d;
        end
    end

`ifdef ERR_COUNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (start_ok) begin
            err_d = 8'd0;
        end else if (busy && dec_valid && (dec_error != 8'd0)
                     && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_dec_error;
    assign unused_dec_error = ^dec_error;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rs_frame_sched.sv
// tb_rs_frame_sched: randomized frame-level bench for rs_frame_sched.
// Each frame's expected timeline is derived from its dec_valid pattern.
module tb_rs_frame_sched;

    localparam int N    = 255;
    localparam int K    = 239;
    localparam int IW   = 256;
    localparam int TO   = 1024;
    localparam int MAXL = 2048;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       dec_valid = 1'b0;
    logic [7:0] dec_error = 8'd0;
    logic       ready, busy, enc_ena, data_present, dec_ena;
    logic       done, timeout;
    logic [7:0] address, position, err_cnt;

    rs_frame_sched #(
        .N(N), .K(K), .INIT_WAIT(IW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .clr(clr), .start(start),
        .dec_valid(dec_valid), .dec_error(dec_error),
        .ready(ready), .busy(busy), .enc_ena(enc_ena),
        .data_present(data_present), .address(address),
        .dec_ena(dec_ena), .position(position), .done(done),
        .timeout(timeout), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       exp_to;
    int         exp_err;

    logic       wv[MAXL];
    logic [7:0] we[MAXL];
    logic       sv[MAXL];
    int         rn[MAXL];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int rdy, input int bsy, input int ena,
                              input int dp, input int adr, input int dena,
                              input int pos, input int dn, input int tmo,
                              input int ec);
        chk("ready", 32'(ready), rdy);
        chk("busy", 32'(busy), bsy);
        chk("enc_ena", 32'(enc_ena), ena);
        chk("data_present", 32'(data_present), dp);
        chk("address", 32'(address), adr);
        chk("dec_ena", 32'(dec_ena), dena);
        chk("position", 32'(position), pos);
        chk("done", 32'(done), dn);
        chk("timeout", 32'(timeout), tmo);
        chk("err_cnt", 32'(err_cnt), ec);
    endtask

    // clr pulse mid-cycle, then the whole init window
    task automatic reset_and_init();
        clr = 1'b1;
        start = 1'b0;
        dec_valid = 1'b0;
        #1;
        check_outs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b0;
        exp_to = 1'b0;
        exp_err = 0;
        for (int c = 0; c < IW; c++) begin
            if (c > 0) step();
            chk("init_ready", 32'(ready), 0);
            chk("init_enc", 32'(enc_ena), 0);
            chk("init_pos", 32'(position), 0);
            start = (c == 100) || (c == IW - 1);
            dec_valid = 1'($urandom % 2);
            dec_error = 8'($urandom);
        end
        step();
        chk("init_done_ready", 32'(ready), 1);
        chk("init_done_enc", 32'(enc_ena), 0);
        start = 1'b0;
        dec_valid = 1'b0;
    endtask

    // typ 0: silent decoder, 1: 255-symbol run from offset 20,
    // 2: random noise plus optional run, 3: run starting before start
    task automatic run_frame(input int typ);
        int   g, d, m, rs, rl, since, ecnt, ec_exp;
        logic tof, latched, hit;
        g = 0;
        for (int i = 0; i < MAXL; i++) begin
            wv[i] = 1'b0;
            we[i] = 8'd0;
            sv[i] = 1'b0;
        end
        case (typ)
            0: g = int'($urandom % 5);
            1: begin
                g = 0;
                for (int k = 0; k < N; k++) begin
                    wv[g + 20 + k] = 1'b1;
                    if (k <= 8 || (k >= 192 && k <= 199))
                        we[g + 20 + k] = 8'($urandom_range(1, 255));
                end
            end
            2: begin
                g = int'($urandom % 40);
                m = int'($urandom % 300);
                for (int i = 0; i < g + m; i++) begin
                    wv[i] = ($urandom % 3) == 0;
                    we[i] = ($urandom % 2) == 0 ? 8'd0 : 8'($urandom);
                end
                if (($urandom % 3) != 0) begin
                    rs = int'($urandom % (g + 500));
                    rl = int'($urandom_range(N - 2, N + 10));
                    for (int k = 0; k < rl; k++) begin
                        wv[rs + k] = 1'b1;
                        we[rs + k] = 8'($urandom % 4);
                    end
                end
            end
            default: begin
                g = 40 + int'($urandom % 10);
                for (int k = 0; k < 300; k++) begin
                    wv[g - 30 + k] = 1'b1;
                    we[g - 30 + k] = 8'($urandom);
                end
            end
        endcase
        sv[g] = 1'b1;
        for (int i = g + 1; i < MAXL; i++) sv[i] = ($urandom % 6) == 0;

        // position = length of the dec_valid run ending last cycle, mod 256
        rn[0] = 0;
        for (int i = 1; i < MAXL; i++)
            rn[i] = wv[i - 1] ? (rn[i - 1] + 1) % 256 : 0;

        d = 0;
        tof = 1'b0;
        latched = 1'b0;
        since = N + 1;
        for (int j = 1; g + j < MAXL - 1 && d == 0; j++) begin
            hit = wv[g + j] && (rn[g + j] == N - 1);
            if (j <= N) begin
                if (hit) latched = 1'b1;
                if (j == N && latched) d = N + 1;
            end else begin
                if (hit) begin
                    d = j + 1;
                end else if (j - since == TO - 1) begin
                    d = j + 1;
                    tof = 1'b1;
                end
                if (wv[g + j]) since = j + 1;
            end
        end
        if (d == 0) begin
            chk("scan_bound", 0, 1);
            d = MAXL - 2 - g;
        end
        wv[g + d] = 1'b0;

        ecnt = 0;
        for (int i = 0; i <= g + d; i++) begin
            int j;
            j = i - g;
            if (i > 0) step();
`ifdef ERR_COUNT_EN
            ec_exp = (j <= 0) ? exp_err : ecnt;
`else
            ec_exp = 0;
`endif
            if (j <= 0) begin
                check_outs(1, 0, 0, 0, 0, 0, rn[i], 0, int'(exp_to), ec_exp);
            end else begin
                check_outs(0, int'(j < d), int'(j <= N), int'(j <= K),
                           (j <= N) ? j - 1 : 0,
                           int'(j >= 2 && j <= N + 1), rn[i],
                           int'(j == d), int'(j == d && tof), ec_exp);
            end
            start = sv[i];
            dec_valid = wv[i];
            dec_error = we[i];
            if (j >= 1 && j < d && wv[i] && we[i] != 8'd0 && ecnt < 255)
                ecnt++;
        end
        step();
        exp_to = tof;
        exp_err = ecnt;
    endtask

    initial begin
        clr = 1'b1;
        repeat (3) step();
        reset_and_init();
        run_frame(0);
        run_frame(1);
        run_frame(1);
        run_frame(3);
        for (int f = 0; f < 8; f++) run_frame(2);

        // abort a frame mid-encode
        start = 1'b1;
        dec_valid = 1'b0;
        step();
        start = 1'b0;
        repeat (100) step();
        chk("mid_addr", 32'(address), 100);
        chk("mid_enc", 32'(enc_ena), 1);
        reset_and_init();
        run_frame(1);
        run_frame(0);
        run_frame(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
